// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the serial transmit controller: FSM state encoding
// and the default frame geometry.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_GAP_CYCLES = 2;
    localparam int GAP_CNT_W      = 4;

endpackage

// File: rtl/shift_tx_ctrl_piso_reg.sv
// Parallel-in serial-out register. The MSB of the register is the serial
// output bit, so the stream comes out MSB first.
module piso_reg
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] sreg_r;

    // Shift register: load wins over clear, clear wins over shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg_r <= '0;
        end else if (load) begin
            sreg_r <= din;
        end else if (clear) begin
            sreg_r <= '0;
        end else if (shift) begin
            sreg_r <= {sreg_r[WIDTH-2:0], 1'b0};
        end else begin
            sreg_r <= sreg_r;
        end
    end

    assign sout = sreg_r[WIDTH-1];

endmodule

// File: rtl/shift_tx_ctrl.sv
// Serial transmit controller: accepts a parallel word through a valid/ready
// handshake, shifts it out MSB first under shift_en, then enforces an idle gap.
module shift_tx_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             shift_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             done,
    output logic             busy,
    output logic [7:0]       frame_cnt
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : {GAP_CNT_W{1'b0}};

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     bit_cnt_r, bit_cnt_s;
    logic [GAP_CNT_W-1:0] gap_cnt_r, gap_cnt_s;
    logic                 ready_r, ready_s;
    logic                 valid_r, valid_s;
    logic                 done_r, done_s;
    logic                 busy_r, busy_s;
    logic [7:0]           frame_r, frame_s;
    logic                 load_s, shift_s, clear_s;
    logic                 sout_s;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, datapath control and next values of every registered output.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        gap_cnt_s = gap_cnt_r;
        ready_s   = ready_r;
        valid_s   = valid_r;
        done_s    = 1'b0;
        frame_s   = frame_r;
        load_s    = 1'b0;
        shift_s   = 1'b0;
        clear_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // ready_r lags IDLE by one edge after reset, so it gates acceptance
                if (din_valid && ready_r) begin
                    load_s    = 1'b1;
                    bit_cnt_s = CNT_LOAD;
                    state_s   = SHIFT;
                    valid_s   = 1'b1;
                    ready_s   = 1'b0;
                end else begin
                    valid_s   = 1'b0;
                    ready_s   = 1'b1;
                end
            end
            SHIFT: begin
                if (shift_en && (bit_cnt_r != {CNT_W{1'b0}})) begin
                    shift_s   = 1'b1;
                    bit_cnt_s = bit_cnt_r - CNT_W'(1);
                end else if (shift_en) begin
                    clear_s   = 1'b1;
                    valid_s   = 1'b0;
                    done_s    = 1'b1;
                    frame_s   = frame_r + 8'd1;
                    if (GAP_CYCLES == 0) begin
                        state_s = IDLE;
                        ready_s = 1'b1;
                    end else begin
                        state_s   = GAP;
                        gap_cnt_s = GAP_LOAD;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            GAP: begin
                if (gap_cnt_r == {GAP_CNT_W{1'b0}}) begin
                    state_s = IDLE;
                    ready_s = 1'b1;
                end else begin
                    gap_cnt_s = gap_cnt_r - GAP_CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                ready_s = 1'b0;
                valid_s = 1'b0;
                clear_s = 1'b1;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // Counters and registered handshake/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_r <= '0;
            gap_cnt_r <= '0;
            ready_r   <= 1'b0;
            valid_r   <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            frame_r   <= 8'd0;
        end else begin
            bit_cnt_r <= bit_cnt_s;
            gap_cnt_r <= gap_cnt_s;
            ready_r   <= ready_s;
            valid_r   <= valid_s;
            done_r    <= done_s;
            busy_r    <= busy_s;
            frame_r   <= frame_s;
        end
    end

    piso_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (load_s),
        .shift (shift_s),
        .clear (clear_s),
        .din   (din),
        .sout  (sout_s)
    );

    assign dout       = sout_s;
    assign dout_valid = valid_r;
    assign din_ready  = ready_r;
    assign done       = done_r;
    assign busy       = busy_r;
    assign frame_cnt  = frame_r;

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Directed bench for shift_tx_ctrl with WIDTH=8, GAP_CYCLES=2.
module tb_shift_tx_ctrl;

    localparam int WIDTH      = 8;
    localparam int GAP_CYCLES = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       shift_en;
    logic       dout;
    logic       dout_valid;
    logic       done;
    logic       busy;
    logic [7:0] frame_cnt;

    int n_vec = 0;
    int n_err = 0;

    shift_tx_ctrl #(
        .WIDTH      (WIDTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .shift_en   (shift_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .done       (done),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 40; i++) begin
            if (din_ready) break;
            tick();
        end
        check("ready_timeout", din_ready, 1);
    endtask

    // Sends one word; optionally holds shift_en low for stall_len edges after the 4th bit.
    task automatic run_frame(input logic [7:0] w, input int stall_len,
                             output logic [7:0] got, output int nvalid, output int ndone,
                             output int done_cyc, output int rdy_cyc, output logic gap_busy);
        int   nbits   = 0;
        int   held    = 0;
        logic prev_en = 1'b1;
        got = 8'h00; nvalid = 0; ndone = 0; done_cyc = -1; rdy_cyc = -1; gap_busy = 1'b0;
        din = w; din_valid = 1'b1; shift_en = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (dout_valid) begin
                nvalid++;
                if (prev_en) begin
                    got = {got[6:0], dout};
                    nbits++;
                end
            end
            if (done) begin
                ndone++;
                done_cyc = c;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) gap_busy = busy && !din_ready;
            if (din_ready) begin
                rdy_cyc = c;
                break;
            end
            if (stall_len > 0 && nbits == 4 && held < stall_len) begin
                shift_en = 1'b0;
                held++;
            end else begin
                shift_en = 1'b1;
            end
            prev_en = shift_en;
            tick();
        end
        shift_en = 1'b1;
    endtask

    initial begin
        logic [7:0] got;
        logic [4:0] got5;
        logic       gap_busy;
        logic       pre;
        int         nvalid, ndone, done_cyc, rdy_cyc;
        int         acc1, acc2, ones, vals, nd;

        reset = 1'b1; din = 8'h00; din_valid = 1'b0; shift_en = 1'b0;
        tick(); tick();
        check("rst_dout",       dout,       0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_done",       done,       0);
        check("rst_busy",       busy,       0);
        check("rst_din_ready",  din_ready,  0);
        check("rst_frame_cnt",  frame_cnt,  0);
        din = 8'h5A; din_valid = 1'b1; shift_en = 1'b1;
        tick();
        check("rst_ignore_valid", dout_valid, 0);
        reset = 1'b0; din_valid = 1'b0;
        #1;
        check("rdy_before_edge", din_ready, 0);
        tick();
        check("rdy_after_release", din_ready, 1);
        check("idle_busy", busy, 0);

        // Plain frame 0xB2
        run_frame(8'hB2, 0, got, nvalid, ndone, done_cyc, rdy_cyc, gap_busy);
        check("b2_bits",     got,    8'hB2);
        check("b2_nvalid",   nvalid, 8);
        check("b2_ndone",    ndone,  1);
        check("b2_done_cyc", done_cyc, 8);
        check("b2_gap_len",  rdy_cyc - done_cyc, 2);
        check("b2_gap_busy", gap_busy, 1);
        check("b2_frame_cnt", frame_cnt, 1);

        // Same frame with a 3-edge stall after the 4th bit
        run_frame(8'hB2, 3, got, nvalid, ndone, done_cyc, rdy_cyc, gap_busy);
        check("stall_bits",   got,    8'hB2);
        check("stall_nvalid", nvalid, 11);
        check("stall_ndone",  ndone,  1);
        check("stall_gap_len", rdy_cyc - done_cyc, 2);
        check("stall_frame_cnt", frame_cnt, 2);

        // din_valid held high: 0xFF then 0x00
        din = 8'hFF; din_valid = 1'b1; shift_en = 1'b1;
        acc1 = -1; acc2 = -1; ones = 0; vals = 0;
        for (int c = 0; c < 40; c++) begin
            pre = din_ready;
            tick();
            if (pre && acc1 < 0) begin
                acc1 = c;
                din  = 8'h00;
            end else if (pre) begin
                acc2 = c;
                break;
            end
            if (dout_valid) begin
                vals++;
                ones += int'(dout);
            end
        end
        din_valid = 1'b0;
        check("b2b_spacing", acc2 - acc1, 11);
        check("b2b_ff_valid", vals, 8);
        check("b2b_ff_ones", ones, 8);
        check("b2b_00_first_valid", dout_valid, 1);
        check("b2b_00_first_bit", dout, 0);
        ones = 0; vals = 0;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (dout_valid) begin
                vals++;
                ones += int'(dout);
            end
        end
        check("b2b_00_valid", vals, 7);
        check("b2b_00_ones", ones, 0);
        tick();
        check("b2b_00_done", done, 1);
        check("b2b_frame_cnt", frame_cnt, 4);

        // Reset mid-frame of 0xA5 after the 5th bit
        wait_ready();
        din = 8'hA5; din_valid = 1'b1; shift_en = 1'b1;
        tick();
        din_valid = 1'b0;
        got5 = 5'b0;
        for (int c = 0; c < 5; c++) begin
            got5 = {got5[3:0], dout};
            if (c < 4) tick();
        end
        check("abort_bits", got5, 5'b10100);
        reset = 1'b1;
        #1;
        check("abort_dout_valid", dout_valid, 0);
        check("abort_done", done, 0);
        check("abort_frame_cnt", frame_cnt, 0);
        check("abort_busy", busy, 0);
        tick();
        check("abort_done_hold", done, 0);
        reset = 1'b0;
        tick();
        check("abort_rdy", din_ready, 1);
        check("abort_done_after", done, 0);
        check("abort_cnt_after", frame_cnt, 0);

        // 257 back-to-back frames to exercise the 255 -> 0 wrap
        din = 8'h3C; din_valid = 1'b1; shift_en = 1'b1;
        nd = 0;
        for (int c = 0; c < 257 * 11 + 40; c++) begin
            tick();
            if (done) begin
                nd++;
                if (nd == 255) check("wrap_255", frame_cnt, 255);
                if (nd == 256) check("wrap_0", frame_cnt, 0);
                if (nd == 257) begin
                    check("wrap_1", frame_cnt, 1);
                    break;
                end
            end
        end
        din_valid = 1'b0;
        check("wrap_done_count", nd, 257);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_tx_ctrl.md
SHIFT_TX_CTRL -- requirements
Module: shift_tx_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, serial word length in bits (legal range 2..32).
REQ-002 Parameter GAP_CYCLES, default 2, idle cycles enforced between frames (legal range 0..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 din_valid  input  1  din holds a word for transfer.
REQ-007 din_ready  output  1  block accepts a word this cycle.
REQ-008 shift_en  input  1  advance-permit for the serial stream; low stalls shifting.
REQ-009 dout  output  1  serial data, MSB first.
REQ-010 dout_valid  output  1  dout carries a valid frame bit.
REQ-011 done  output  1  one-cycle pulse when a frame's last bit has been consumed.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 frame_cnt  output  8  count of completed frames, wraps modulo 256.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and GAP; all outputs are registered.
REQ-015 Handshake: a word is accepted at a rising edge where din_valid=1 and din_ready=1; din_ready=1 only in IDLE.
REQ-016 din_valid while din_ready=0 SHALL be ignored; no data captured, no state change.
REQ-017 On acceptance: load din into the shift register, bit counter = WIDTH-1, state -> SHIFT, dout = din[WIDTH-1], dout_valid = 1, din_ready = 0 (all visible in the cycle after the accepting edge).
REQ-018 In SHIFT, each edge with shift_en=1 and counter > 0: present next lower bit on dout, decrement counter.
REQ-019 In SHIFT, edges with shift_en=0: dout, dout_valid, counter and register held unchanged.
REQ-020 Edge with shift_en=1 and counter = 0: dout_valid -> 0, dout -> 0, done -> 1 for exactly one cycle, frame_cnt increments.
REQ-021 After the last bit: if GAP_CYCLES = 0, state -> IDLE and din_ready -> 1 at that same edge; else state -> GAP.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles with din_ready = 0, then state -> IDLE and din_ready -> 1.
REQ-023 shift_en SHALL be ignored in IDLE and GAP.
REQ-024 With shift_en held at 1, a frame occupies WIDTH cycles of dout_valid; minimum accept-to-accept period = WIDTH + 1 + GAP_CYCLES cycles.
REQ-025 frame_cnt SHALL wrap 255 -> 0 without any other side effect.
REQ-026 busy = 1 in SHIFT and GAP, 0 in IDLE.

Reset
REQ-027 While reset = 1: state = IDLE, dout = 0, dout_valid = 0, done = 0, busy = 0, din_ready = 0, frame_cnt = 0, counters and shift register = 0.
REQ-028 din_ready SHALL rise at the first rising edge after reset deassertion.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately (asynchronous); no done pulse, no frame_cnt increment, partial word discarded.

Structure
REQ-030 Package shift_ctrl_pkg SHALL hold the state encoding (IDLE, SHIFT, GAP) and the default WIDTH/GAP_CYCLES constants.
REQ-031 The datapath SHALL be a sub-module piso_reg (WIDTH parameter; load, shift, clk, reset ports) instantiated by the controller FSM.

Verification (WIDTH = 8, GAP_CYCLES = 2)
REQ-032 Reset, then din = 8'hB2 with din_valid = 1 and shift_en = 1 -> dout = 1,0,1,1,0,0,1,0 over 8 consecutive dout_valid cycles; done pulses once; frame_cnt = 1; din_ready returns 2 cycles after done.
REQ-033 Same frame with shift_en = 0 for 3 cycles after the 4th bit -> 4th bit held 3 extra cycles, 11 dout_valid cycles total, bit sequence unchanged.
REQ-034 din_valid held high continuously with 8'hFF then 8'h00 -> accepts spaced exactly 11 cycles apart; 8'h00 ignored while din_ready = 0, then accepted.
REQ-035 Reset pulsed after the 5th bit of 8'hA5 -> dout_valid = 0 immediately, no done, frame_cnt = 0, din_ready = 1 one edge after release.
REQ-036 256 back-to-back frames -> frame_cnt reads 0 after the last done, 1 after one more frame.
